vga_timing_generator: RTL and testbench

Parametrised successor to the fixed 640x480 horizontal counter: generates both horizontal and vertical raster timing, sync pulses of configurable polarity, a display-enable window and pixel-replicated (scaled) framebuffer coordinates. It advances only on a pixel-clock enable, so the system clock may run faster than the pixel rate. It sits between the clock/reset logic and the framebuffer read / colour output stage.

---
 rtl/vga_timing_pkg.sv | 45 ++++
 rtl/timing_axis_counter.sv | 109 ++++++++++
 rtl/vga_timing_generator.sv | 92 +++++++++
 tb/tb_vga_timing_generator.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and elaboration helpers for the VGA raster timing generator.
// Holds the 640x480@60 default mode, the per-axis TOTAL/START arithmetic, a
// width helper that never returns a zero-width vector, and the parameter
// legality check used by each axis counter.
package vga_timing_pkg;

    // 640x480@60 (25.175 MHz pixel rate) default mode.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_H_POL    = 1'b0;
    localparam bit DEF_V_POL    = 1'b0;
    localparam int DEF_H_SCALE  = 5;
    localparam int DEF_V_SCALE  = 5;

    // Positions per line (or lines per frame) for one axis.
    function automatic int axis_total(input int sync, input int bp, input int active, input int fp);
        return sync + bp + active + fp;
    endfunction

    // First active position: sync comes first, then back porch.
    function automatic int axis_start(input int sync, input int bp);
        return sync + bp;
    endfunction

    // $clog2 clamped to at least one bit so degenerate ranges stay legal.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Every region must be non-empty and the replication factor must tile
    // the active region exactly, otherwise the scaled counter would not land
    // on ACTIVE/SCALE-1 at the last active position.
    function automatic bit axis_params_ok(input int active, input int scale,
                                          input int sync, input int bp, input int fp);
        return (sync >= 1) && (bp >= 1) && (fp >= 1) && (scale >= 1) &&
               (active >= scale) && ((active % scale) == 0);
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis (horizontal or vertical).
// Ports:
//   clk_i, rst_i : clock and asynchronous active-high reset
//   adv_i        : step the axis by one position this cycle
//   cnt_o        : current position, 0..TOTAL-1
//   scl_o        : replicated (scaled) coordinate inside the active region
//   sync_o       : POL while position < SYNC, ~POL otherwise
//   active_o     : position lies inside [START, START+ACTIVE)
//   wrap_o       : combinational, adv_i while at TOTAL-1 (the wrapping edge)
// sync_o, active_o and scl_o are registered from next-state values so they
// always describe the cnt_o presented in the same cycle.
module timing_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = DEF_H_POL,
    parameter int SCALE  = DEF_H_SCALE,
    localparam int CW    = clog2_min1(axis_total(SYNC, BP, ACTIVE, FP)),
    localparam int SW    = clog2_min1(ACTIVE / SCALE)
)(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          adv_i,
    output logic [CW-1:0] cnt_o,
    output logic [SW-1:0] scl_o,
    output logic          sync_o,
    output logic          active_o,
    output logic          wrap_o
);

    localparam int TOTAL = axis_total(SYNC, BP, ACTIVE, FP);
    localparam int START = axis_start(SYNC, BP);
    localparam int PW    = clog2_min1(SCALE);

    localparam logic [CW-1:0] LAST_C       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_C       = CW'(SYNC);
    localparam logic [CW-1:0] START_C      = CW'(START);
    localparam logic [CW-1:0] ACT_LAST_C   = CW'(START + ACTIVE - 1);
    localparam logic [PW-1:0] PHASE_LAST_C = PW'(SCALE - 1);

    if (!axis_params_ok(ACTIVE, SCALE, SYNC, BP, FP)) begin : g_bad_params
        $error("timing_axis_counter: illegal ACTIVE/SCALE/SYNC/BP/FP combination");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [SW-1:0] scl_q, scl_d;
    logic          sync_q, sync_d;
    logic          active_q, active_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST_C);
    assign wrap_o  = adv_i & at_last;

    // The phase counter replaces a divide by SCALE: the scaled coordinate
    // steps whenever the phase rolls over inside the active region. Leaving
    // the active region never rolls it, so the last value holds through the
    // front porch until the wrap clears it.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        scl_d   = scl_q;
        if (adv_i) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
            if (cnt_d == START_C) begin
                phase_d = '0;
                scl_d   = '0;
            end else if ((cnt_d > START_C) && (cnt_d <= ACT_LAST_C)) begin
                if (phase_q == PHASE_LAST_C) begin
                    phase_d = '0;
                    scl_d   = scl_q + 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end else if (at_last) begin
                phase_d = '0;
                scl_d   = '0;
            end
        end
    end

    assign sync_d   = (cnt_d < SYNC_C) ? POL : ~POL;
    assign active_d = (cnt_d >= START_C) && (cnt_d <= ACT_LAST_C);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            phase_q  <= '0;
            scl_q    <= '0;
            sync_q   <= POL;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            scl_q    <= scl_d;
            sync_q   <= sync_d;
            active_q <= active_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign scl_o    = scl_q;
    assign sync_o   = sync_q;
    assign active_o = active_q;

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing generator: horizontal and vertical counters, sync pulses
// of configurable polarity, display-enable window and pixel-replicated
// framebuffer coordinates, all advancing only on pix_en.
// Ports:
//   clk, reset      : system clock, asynchronous active-high reset
//   pix_en          : pixel-clock enable
//   hor_cnt/ver_cnt : raster position
//   scl_hor_cnt/scl_ver_cnt : scaled framebuffer column/row
//   HSYNC, VSYNC    : sync outputs
//   display_en      : inside the active window on both axes
//   new_line        : combinational strobe on the line-wrap edge
//   new_frame       : combinational strobe on the frame-wrap edge
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = DEF_H_POL,
    parameter bit V_POL    = DEF_V_POL,
    parameter int H_SCALE  = DEF_H_SCALE,
    parameter int V_SCALE  = DEF_V_SCALE,
    localparam int HW      = clog2_min1(axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP)),
    localparam int VW      = clog2_min1(axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP)),
    localparam int SHW     = clog2_min1(H_ACTIVE / H_SCALE),
    localparam int SVW     = clog2_min1(V_ACTIVE / V_SCALE)
)(
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_en,
    output logic [HW-1:0]  hor_cnt,
    output logic [VW-1:0]  ver_cnt,
    output logic [SHW-1:0] scl_hor_cnt,
    output logic [SVW-1:0] scl_ver_cnt,
    output logic           HSYNC,
    output logic           VSYNC,
    output logic           display_en,
    output logic           new_line,
    output logic           new_frame
);

    logic h_active, v_active;
    logic h_wrap, v_wrap;

    timing_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL),
        .SCALE  (H_SCALE)
    ) u_h_axis (
        .clk_i    (clk),
        .rst_i    (reset),
        .adv_i    (pix_en),
        .cnt_o    (hor_cnt),
        .scl_o    (scl_hor_cnt),
        .sync_o   (HSYNC),
        .active_o (h_active),
        .wrap_o   (h_wrap)
    );

    // The vertical axis steps on the horizontal wrap, which already carries
    // pix_en, so its wrap output is the frame strobe.
    timing_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL),
        .SCALE  (V_SCALE)
    ) u_v_axis (
        .clk_i    (clk),
        .rst_i    (reset),
        .adv_i    (h_wrap),
        .cnt_o    (ver_cnt),
        .scl_o    (scl_ver_cnt),
        .sync_o   (VSYNC),
        .active_o (v_active),
        .wrap_o   (v_wrap)
    );

    assign display_en = h_active & v_active;
    assign new_line   = h_wrap;
    assign new_frame  = v_wrap;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: a default 640x480 instance and a small
// 10x10 instance (sync/porches 2, active 4, scale 2, positive polarity, so
// H_TOTAL = V_TOTAL = 2+2+4+2 = 10 and the double strobe sits at (9,9)).
// Each driver step pushes the expected outputs for that cycle; a negedge
// monitor pops and compares them.
module tb_vga_timing_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic       rst_def = 1'b1;
    logic       en_def  = 1'b0;
    logic [9:0] hor_d, ver_d;
    logic [6:0] sclh_d, sclv_d;
    logic       hs_d, vs_d, de_d, nl_d, nf_d;

    // Small instance
    logic       rst_sml = 1'b1;
    logic       en_sml  = 1'b0;
    logic [3:0] hor_s, ver_s;
    logic [0:0] sclh_s, sclv_s;
    logic       hs_s, vs_s, de_s, nl_s, nf_s;

    vga_timing_generator u_dut_def (
        .clk         (clk),
        .reset       (rst_def),
        .pix_en      (en_def),
        .hor_cnt     (hor_d),
        .ver_cnt     (ver_d),
        .scl_hor_cnt (sclh_d),
        .scl_ver_cnt (sclv_d),
        .HSYNC       (hs_d),
        .VSYNC       (vs_d),
        .display_en  (de_d),
        .new_line    (nl_d),
        .new_frame   (nf_d)
    );

    vga_timing_generator #(
        .H_ACTIVE (4), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .H_POL (1'b1), .V_POL (1'b1), .H_SCALE (2), .V_SCALE (2)
    ) u_dut_sml (
        .clk         (clk),
        .reset       (rst_sml),
        .pix_en      (en_sml),
        .hor_cnt     (hor_s),
        .ver_cnt     (ver_s),
        .scl_hor_cnt (sclh_s),
        .scl_ver_cnt (sclv_s),
        .HSYNC       (hs_s),
        .VSYNC       (vs_s),
        .display_en  (de_s),
        .new_line    (nl_s),
        .new_frame   (nf_s)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int          at_cyc;
        int          sel;
        int          h;
        int          v;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   k_def   = 0;
    int   k_sml   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Directed points {h, v, signal index, value}; index 2 scl_hor, 3 scl_ver,
    // 4 HSYNC, 5 VSYNC, 6 display_en, 7 new_line, 8 new_frame.
    int dir_def [20][4] = '{
        '{95,0,4,0},    '{96,0,4,1},    '{798,0,7,0},   '{799,0,7,1},
        '{799,1,5,0},   '{0,2,5,1},     '{144,34,6,0},  '{143,35,6,0},
        '{144,35,6,1},  '{783,35,6,1},  '{784,35,6,0},  '{144,35,2,0},
        '{148,35,2,0},  '{149,35,2,1},  '{779,35,2,127},'{783,35,2,127},
        '{799,35,2,127},'{0,36,2,0},    '{799,39,3,0},  '{0,40,3,1}
    };
    int dir_sml [20][4] = '{
        '{0,0,4,1}, '{1,0,4,1}, '{2,0,4,0}, '{0,1,5,1}, '{0,2,5,0},
        '{4,4,6,1}, '{7,7,6,1}, '{8,7,6,0}, '{3,4,6,0}, '{4,3,6,0},
        '{7,4,2,1}, '{9,4,2,1}, '{0,5,2,0}, '{5,4,2,0}, '{9,9,7,1},
        '{9,9,8,1}, '{9,8,8,0}, '{8,9,7,0}, '{0,6,3,1}, '{5,4,3,0}
    };

    function automatic string sel_name(input int sel);
        case (sel % 10)
            0: return "hor_cnt";
            1: return "ver_cnt";
            2: return "scl_hor_cnt";
            3: return "scl_ver_cnt";
            4: return "HSYNC";
            5: return "VSYNC";
            6: return "display_en";
            7: return "new_line";
            8: return "new_frame";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] get_act(input int sel);
        case (sel)
            0:  return 32'(hor_d);
            1:  return 32'(ver_d);
            2:  return 32'(sclh_d);
            3:  return 32'(sclv_d);
            4:  return 32'(hs_d);
            5:  return 32'(vs_d);
            6:  return 32'(de_d);
            7:  return 32'(nl_d);
            8:  return 32'(nf_d);
            10: return 32'(hor_s);
            11: return 32'(ver_s);
            12: return 32'(sclh_s);
            13: return 32'(sclv_s);
            14: return 32'(hs_s);
            15: return 32'(vs_s);
            16: return 32'(de_s);
            17: return 32'(nl_s);
            18: return 32'(nf_s);
            default: return '1;
        endcase
    endfunction

    // Monitor: compare every expectation issued for the current cycle.
    exp_t        mon_e;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at_cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            if (mon_e.at_cyc != cyc) begin
                n_fail++;
                $display("FAIL stale_%s%s at h=%0d v=%0d: issued cycle %0d, now %0d",
                         (mon_e.sel >= 10) ? "sml_" : "def_", sel_name(mon_e.sel),
                         mon_e.h, mon_e.v, mon_e.at_cyc, cyc);
            end else begin
                mon_act = get_act(mon_e.sel);
                if (mon_act !== mon_e.val) begin
                    n_fail++;
                    $display("FAIL %s%s at h=%0d v=%0d: got %0d expected %0d",
                             (mon_e.sel >= 10) ? "sml_" : "def_", sel_name(mon_e.sel),
                             mon_e.h, mon_e.v, mon_act, mon_e.val);
                end
            end
        end
    end

    // ---------------- expectation model ----------------
    function automatic int exp_scl(input int pos, input int start, input int active, input int scale);
        if (pos < start) return 0;
        if (pos < start + active) return (pos - start) / scale;
        return active / scale - 1;
    endfunction

    task automatic push(input int sel, input int h, input int v, input logic [31:0] val);
        exp_t e;
        e.at_cyc = cyc;
        e.sel    = sel;
        e.h      = h;
        e.v      = v;
        e.val    = val;
        exp_q.push_back(e);
    endtask

    task automatic push_model(input bit sml, input int k, input bit en);
        int ht, vt, hsy, hst, ha, vsy, vst, va, hsc, vsc, base, h, v;
        bit hp, vp, h_in, v_in;
        if (sml) begin
            ht = 10; vt = 10; hsy = 2; hst = 4; ha = 4; vsy = 2; vst = 4; va = 4;
            hsc = 2; vsc = 2; hp = 1'b1; vp = 1'b1; base = 10;
        end else begin
            ht = 800; vt = 525; hsy = 96; hst = 144; ha = 640; vsy = 2; vst = 35; va = 480;
            hsc = 5; vsc = 5; hp = 1'b0; vp = 1'b0; base = 0;
        end
        h    = k % ht;
        v    = (k / ht) % vt;
        h_in = (h >= hst) && (h < hst + ha);
        v_in = (v >= vst) && (v < vst + va);
        push(base + 0, h, v, 32'(h));
        push(base + 1, h, v, 32'(v));
        push(base + 2, h, v, 32'(exp_scl(h, hst, ha, hsc)));
        push(base + 3, h, v, 32'(exp_scl(v, vst, va, vsc)));
        push(base + 4, h, v, 32'((h < hsy) ? hp : !hp));
        push(base + 5, h, v, 32'((v < vsy) ? vp : !vp));
        push(base + 6, h, v, 32'(h_in && v_in));
        push(base + 7, h, v, 32'(en && (h == ht - 1)));
        push(base + 8, h, v, 32'(en && (h == ht - 1) && (v == vt - 1)));
    endtask

    task automatic push_directed(input bit sml, input int k);
        int h, v;
        if (sml) begin
            h = k % 10;
            v = (k / 10) % 10;
            for (int i = 0; i < 20; i++)
                if (dir_sml[i][0] == h && dir_sml[i][1] == v)
                    push(10 + dir_sml[i][2], h, v, 32'(dir_sml[i][3]));
        end else begin
            h = k % 800;
            v = (k / 800) % 525;
            for (int i = 0; i < 20; i++)
                if (dir_def[i][0] == h && dir_def[i][1] == v)
                    push(dir_def[i][2], h, v, 32'(dir_def[i][3]));
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit sml, input bit en, input bit rst, input bit directed);
        int k;
        @(posedge clk);
        #1;
        if (sml) begin
            rst_sml = rst;
            en_sml  = en;
            if (rst) k_sml = 0;
            k = k_sml;
        end else begin
            rst_def = rst;
            en_def  = en;
            if (rst) k_def = 0;
            k = k_def;
        end
        push_model(sml, k, en && !rst);
        if (directed && en && !rst) push_directed(sml, k);
        if (en && !rst) begin
            if (sml) k_sml++;
            else     k_def++;
        end
    endtask

    initial begin : watchdog
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        // Default mode: reset values, then continuous pixel enable through
        // line 40 so the active window and the vertical scale are reached.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 41 * 800 + 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1);

        // 1-in-3 random enable: positions advance only on enabled cycles.
        for (int i = 0; i < 4800; i++)
            step(1'b0, ($urandom_range(0, 2) == 0), 1'b0, 1'b0);

        // Mid-line, mid-frame reset at hor_cnt = 400 (an active pixel).
        for (int i = 0; i < 800 && (k_def % 800) != 400; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Small mode: polarity, region edges, (9,9) double strobe, 100-cycle frame.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 250; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 150; i++)
            step(1'b1, ($urandom_range(0, 2) == 0), 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL unchecked_%s at h=%0d v=%0d: never compared, expected %0d",
                     sel_name(e.sel), e.h, e.v, e.val);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
